sprite_upload_ctrl: RTL and testbench

Upstream loader for `sprite_storage`. Takes the byte stream delivered by the SPI receiver and turns each sprite-upload packet into sprite-storage write cycles: `sprite_select`, `w_en`, `w_addr`, `w_data`. Each data byte carries two 4-bit pixels. The block also flags malformed or truncated packets and tells the renderer when a sprite bank is being rewritten.

---
 rtl/sprite_upload_ctrl.sv | 136 +++++++++++++
 tb/tb_sprite_upload_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_upload_ctrl.sv
// Sprite-upload packet loader: header + 2^SPRITE_ADDR_SIZE data bytes -> sprite_storage writes.
// Define SPRITE_UPLOAD_CHECKSUM_EN to require a trailing XOR checksum byte per packet.
module sprite_upload_ctrl #(
  parameter int SPRITE_NUM       = 8,
  parameter int SPRITE_ADDR_SIZE = 7,
  localparam int IDX_W           = (SPRITE_NUM > 1) ? $clog2(SPRITE_NUM) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_active,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic [IDX_W-1:0]          sprite_select,
  output logic                      w_en,
  output logic [SPRITE_ADDR_SIZE:0] w_addr,
  output logic [7:0]                w_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
`ifdef SPRITE_UPLOAD_CHECKSUM_EN
    ST_CHECK = 2'd2,
`endif
    ST_DRAIN = 2'd3
  } state_t;

  state_t                      state_reg;
  logic [SPRITE_ADDR_SIZE-1:0] cnt_reg;
`ifdef SPRITE_UPLOAD_CHECKSUM_EN
  logic [7:0]                  xor_reg;
`endif

  logic [31:0] hdr_idx;
  logic        hdr_ok;
  logic        last_byte;

  assign hdr_idx   = {26'd0, rx_data[5:0]};
  assign hdr_ok    = (rx_data[7:6] == 2'b01) && (hdr_idx < 32'(SPRITE_NUM));
  assign last_byte = &cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
`ifdef SPRITE_UPLOAD_CHECKSUM_EN
      xor_reg       <= '0;
`endif
      sprite_select <= '0;
      w_en          <= 1'b0;
      w_addr        <= '0;
      w_data        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      w_en <= 1'b0;
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (frame_active && rx_valid) begin
            if (hdr_ok) begin
              sprite_select <= rx_data[IDX_W-1:0];
              cnt_reg       <= '0;
`ifdef SPRITE_UPLOAD_CHECKSUM_EN
              xor_reg       <= '0;
`endif
              err           <= 1'b0;
              busy          <= 1'b1;
              state_reg     <= ST_LOAD;
            end else begin
              err       <= 1'b1;
              state_reg <= ST_DRAIN;
            end
          end
        end

        ST_LOAD: begin
          // Frame end wins over a byte strobed in the same cycle.
          if (!frame_active) begin
            err       <= 1'b1;
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (rx_valid) begin
            w_en    <= 1'b1;
            w_data  <= rx_data;
            w_addr  <= {cnt_reg, 1'b0};
            cnt_reg <= cnt_reg + 1'b1;
`ifdef SPRITE_UPLOAD_CHECKSUM_EN
            xor_reg <= xor_reg ^ rx_data;
            if (last_byte) begin
              state_reg <= ST_CHECK;
            end
`else
            if (last_byte) begin
              done      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= ST_DRAIN;
            end
`endif
          end
        end

`ifdef SPRITE_UPLOAD_CHECKSUM_EN
        ST_CHECK: begin
          if (!frame_active) begin
            err       <= 1'b1;
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (rx_valid) begin
            if (rx_data == xor_reg) begin
              done <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            busy      <= 1'b0;
            state_reg <= ST_DRAIN;
          end
        end
`endif

        ST_DRAIN: begin
          if (!frame_active) begin
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_upload_ctrl.sv
// Directed bench for sprite_upload_ctrl (4 banks, 4-byte sprites) with a write scoreboard.
// Step 6 runs only when SPRITE_UPLOAD_CHECKSUM_EN is defined.
module tb_sprite_upload_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_active = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [1:0] sprite_select;
  logic       w_en;
  logic [2:0] w_addr;
  logic [7:0] w_data;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [12:0] sb[$];

  sprite_upload_ctrl #(.SPRITE_NUM(4), .SPRITE_ADDR_SIZE(2)) dut (
    .clk(clk), .rst_n(rst_n), .frame_active(frame_active),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .sprite_select(sprite_select), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every write must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (w_en === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed sel=%0d addr=%0d data=%0h expected no write",
               sprite_select, w_addr, w_data);
      end
      if (sb.size() != 0) begin
        chk("write", {19'd0, sprite_select, w_addr, w_data}, {19'd0, sb.pop_front()});
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
`ifndef SPRITE_UPLOAD_CHECKSUM_EN
      chk("done_with_final_write", {28'd0, w_en, w_addr}, {28'd0, 1'b1, 3'd6});
`endif
    end
  end

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_data(input logic [1:0] sel, input int idx, input logic [7:0] b);
    logic [2:0] addr;
    addr = 3'(idx * 2);
    sb.push_back({sel, addr, b});
    send(b);
  endtask

  task automatic send_sprite(input logic [7:0] hdr, input logic [31:0] d);
    logic [7:0] cs;
    cs = 8'h00;
    send(hdr);
    chk("busy_after_hdr", {31'd0, busy}, 32'd1);
    chk("err_cleared_by_hdr", {31'd0, err}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      send_data(hdr[1:0], i, d[31-8*i -: 8]);
      cs = cs ^ d[31-8*i -: 8];
    end
`ifdef SPRITE_UPLOAD_CHECKSUM_EN
    send(cs);
`endif
    exp_done++;
  endtask

  task automatic end_frame();
    frame_active = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sel"},    {30'd0, sprite_select}, 32'd0);
    chk({tag, "_w_en"},   {31'd0, w_en},   32'd0);
    chk({tag, "_w_addr"}, {29'd0, w_addr}, 32'd0);
    chk({tag, "_w_data"}, {24'd0, w_data}, 32'd0);
    chk({tag, "_busy"},   {31'd0, busy},   32'd0);
    chk({tag, "_done"},   {31'd0, done},   32'd0);
    chk({tag, "_err"},    {31'd0, err},    32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: nominal upload to bank 1
    frame_active = 1'b1;
    send_sprite(8'h41, 32'h12345678);
`ifndef SPRITE_UPLOAD_CHECKSUM_EN
    chk("t1_busy_drops", {31'd0, busy}, 32'd0);
`endif
    end_frame();
    chk("t1_done_cnt", done_cnt, exp_done);
    chk("t1_err", {31'd0, err}, 32'd0);
    chk("t1_sel", {30'd0, sprite_select}, 32'd1);
    chk("t1_sb_empty", sb.size(), 32'd0);

    // 2: out-of-range index, then a valid packet clears err
    frame_active = 1'b1;
    send(8'h45);
    chk("t2_err_set", {31'd0, err}, 32'd1);
    chk("t2_busy_low", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i));
    chk("t2_busy_still_low", {31'd0, busy}, 32'd0);
    end_frame();
    chk("t2_err_sticky", {31'd0, err}, 32'd1);
    chk("t2_sel_held", {30'd0, sprite_select}, 32'd1);
    frame_active = 1'b1;
    send_sprite(8'h40, 32'hCAFEBEEF);
    end_frame();
    chk("t2_sel_bank0", {30'd0, sprite_select}, 32'd0);
    chk("t2_done_cnt", done_cnt, exp_done);

    // 3: truncated packet
    frame_active = 1'b1;
    send(8'h42);
    send_data(2'd2, 0, 8'h9A);
    send_data(2'd2, 1, 8'hBC);
    end_frame();
    chk("t3_err", {31'd0, err}, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    chk("t3_no_done", done_cnt, exp_done);
    chk("t3_sb_empty", sb.size(), 32'd0);

    // 4: extra bytes after a complete sprite are ignored
    frame_active = 1'b1;
    send_sprite(8'h43, 32'h0F1E2D3C);
    send(8'hAA);
    send(8'h41);
    end_frame();
    chk("t4_done_cnt", done_cnt, exp_done);
    chk("t4_err", {31'd0, err}, 32'd0);
    chk("t4_sel", {30'd0, sprite_select}, 32'd3);
    chk("t4_sb_empty", sb.size(), 32'd0);

    // 5: reset mid-packet
    frame_active = 1'b1;
    send(8'h41);
    send_data(2'd1, 0, 8'h11);
    send_data(2'd1, 1, 8'h22);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t5_reset");
    send(8'h33);
    send(8'h44);
    rst_n = 1'b1;
    end_frame();
    chk("t5_no_write", {31'd0, w_en}, 32'd0);
    chk("t5_sb_empty", sb.size(), 32'd0);
    chk("t5_no_done", done_cnt, exp_done);

`ifdef SPRITE_UPLOAD_CHECKSUM_EN
    // 6: checksum good then bad
    frame_active = 1'b1;
    send(8'h41);
    for (int i = 0; i < 4; i++) send_data(2'd1, i, 8'h12 + 8'(i) * 8'h22);
    send(8'h08);
    exp_done++;
    end_frame();
    chk("t6_good_done", done_cnt, exp_done);
    chk("t6_good_err", {31'd0, err}, 32'd0);
    frame_active = 1'b1;
    send(8'h41);
    for (int i = 0; i < 4; i++) send_data(2'd1, i, 8'h12 + 8'(i) * 8'h22);
    send(8'h09);
    end_frame();
    chk("t6_bad_no_done", done_cnt, exp_done);
    chk("t6_bad_err", {31'd0, err}, 32'd1);
    chk("t6_sb_empty", sb.size(), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
